// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Pure declarations: no latency, no flow control.
package fetch_pkg;

    localparam int          INSTR_W      = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic [31:0] PC_PLUS8     = 32'd8;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] addr;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Redirect targets are word addresses; the low two bits are discarded.
    function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry prefetch FIFO of {addr, instr}; push visible at head one cycle later.
// No internal backpressure: caller reserves space via full_o/count_o; flush empties it.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  fetch_entry_t           push_dat_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output fetch_entry_t           head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_i && !pop_i)      count_q <= count_q + CW'(1);
            else if (pop_i && !push_i) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem requests, buffers words, redirects on PCSrc.
// Request-accept to instr_valid is 2 cycles with 1-cycle memory; requests stall when buffer plus in-flight reach DEPTH.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] Instr,
    output logic [31:0] PCPlus8,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic [31:0] Result
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic          started_q;

    logic [CW-1:0] buf_count;
    logic          buf_full;
    logic          buf_empty;
    fetch_entry_t  buf_head;
    fetch_entry_t  push_dat;
    logic [CW:0]   reserved;
    logic          req_accept;
    logic          redirect;
    logic          push;
    logic          pop;

    // Every accepted request owns a buffer slot until it is popped or flushed.
    assign reserved       = {1'b0, outstanding_q} + {1'b0, buf_count};
    assign imem_req_valid = started_q && (state_q == RUN) && (reserved < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_accept     = imem_req_valid && imem_req_ready;

    assign instr_valid = !buf_empty;
    assign Instr       = instr_valid ? buf_head.instr : '0;
    assign PCPlus8     = instr_valid ? (buf_head.addr + PC_PLUS8) : '0;

    assign redirect = PCSrc && instr_valid && instr_ready;
    assign pop      = instr_valid && instr_ready && !redirect;
    assign push     = imem_rsp_valid && (state_q == RUN) && !redirect && (!buf_full || pop);
    assign push_dat = '{addr: rsp_pc_q, instr: imem_rsp_data};

    assign outstanding_d = outstanding_q + CW'(req_accept) - CW'(imem_rsp_valid);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        if (req_accept) fetch_pc_d = fetch_pc_q + PC_INC;
        if (push)       rsp_pc_d   = rsp_pc_q + PC_INC;
        if (redirect) begin
            fetch_pc_d = align_pc(Result);
            rsp_pc_d   = align_pc(Result);
            // Wrong-path requests still in flight must return before fetching resumes.
            state_d    = (outstanding_d != '0) ? DRAIN : RUN;
        end else if (state_q == DRAIN && outstanding_d == '0) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            started_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            started_q     <= 1'b1;
        end
    end

    fetch_buffer #(
        .DEPTH(DEPTH)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .flush_i    (redirect),
        .full_o     (buf_full),
        .empty_o    (buf_empty),
        .count_o    (buf_count),
        .head_o     (buf_head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: instance A (DEPTH 2, PC 0) and instance B (DEPTH 4, PC 0xFFFF_FFF8)
// share control inputs; each has its own 1-cycle memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_ready;
    logic        instr_ready;
    logic        PCSrc;
    logic [31:0] Result;

    logic        req_valid_a, rsp_valid_a, iv_a;
    logic [31:0] req_addr_a, rsp_data_a, instr_a, pcp8_a;
    logic        req_valid_b, rsp_valid_b, iv_b;
    logic [31:0] req_addr_b, rsp_data_b, instr_b, pcp8_b;

    int          checks = 0;
    int          fails  = 0;
    int          acc_cnt_a = 0;
    logic [31:0] last_acc_a = '0;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .reset(reset),
        .imem_req_valid(req_valid_a), .imem_req_addr(req_addr_a), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(rsp_valid_a), .imem_rsp_data(rsp_data_a),
        .instr_valid(iv_a), .Instr(instr_a), .PCPlus8(pcp8_a),
        .instr_ready(instr_ready), .PCSrc(PCSrc), .Result(Result)
    );

    fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .reset(reset),
        .imem_req_valid(req_valid_b), .imem_req_addr(req_addr_b), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(rsp_valid_b), .imem_rsp_data(rsp_data_b),
        .instr_valid(iv_b), .Instr(instr_b), .PCPlus8(pcp8_b),
        .instr_ready(instr_ready), .PCSrc(PCSrc), .Result(Result)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hE3A0_0000;
    endfunction

    // One clock: sample accepts before the edge, return their words 1 cycle later, end on negedge.
    task automatic tick();
        logic        acc_a, acc_b;
        logic [31:0] ad_a, ad_b;
        acc_a = req_valid_a & imem_req_ready;
        acc_b = req_valid_b & imem_req_ready;
        ad_a  = req_addr_a;
        ad_b  = req_addr_b;
        if (acc_a) begin
            acc_cnt_a++;
            last_acc_a = ad_a;
        end
        @(posedge clk);
        #1;
        rsp_valid_a = acc_a;
        rsp_data_a  = word(ad_a);
        rsp_valid_b = acc_b;
        rsp_data_b  = word(ad_b);
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge of the first cycle after release.
    task automatic do_reset();
        reset       = 1'b0;
        PCSrc       = 1'b0;
        rsp_valid_a = 1'b0;
        rsp_valid_b = 1'b0;
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        acc_cnt_a = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0; PCSrc = 1'b0; Result = '0; imem_req_ready = 1'b1; instr_ready = 1'b1;
        rsp_valid_a = 1'b0; rsp_data_a = '0; rsp_valid_b = 1'b0; rsp_data_b = '0;
        repeat (2) @(negedge clk);
        checks++; if (req_valid_a !== 1'b0) begin fails++; $display("FAIL rst_req_valid_a got=%b want=0", req_valid_a); end
        checks++; if (iv_a !== 1'b0) begin fails++; $display("FAIL rst_instr_valid_a got=%b want=0", iv_a); end
        checks++; if (instr_a !== 32'h0) begin fails++; $display("FAIL rst_instr_a got=%h want=0", instr_a); end
        checks++; if (pcp8_a !== 32'h0) begin fails++; $display("FAIL rst_pcplus8_a got=%h want=0", pcp8_a); end
        checks++; if (req_valid_b !== 1'b0) begin fails++; $display("FAIL rst_req_valid_b got=%b want=0", req_valid_b); end
        reset = 1'b1;
        checks++; if (req_valid_a !== 1'b0) begin fails++; $display("FAIL start_cycle1_req got=%b want=0", req_valid_a); end
        tick();
        checks++; if (req_valid_a !== 1'b1 || req_addr_a !== 32'h0) begin fails++; $display("FAIL start_cycle2_req got=%b/%h want=1/00000000", req_valid_a, req_addr_a); end
    endtask

    task automatic test_stream();
        tick();
        checks++; if (req_addr_a !== 32'h4 || iv_a !== 1'b0) begin fails++; $display("FAIL stream_c3 addr=%h iv=%b want 00000004/0", req_addr_a, iv_a); end
        tick();
        checks++; if (iv_a !== 1'b1 || pcp8_a !== 32'h8) begin fails++; $display("FAIL stream_c4_head iv=%b pcp8=%h want 1/00000008", iv_a, pcp8_a); end
        checks++; if (instr_a !== word(32'h0)) begin fails++; $display("FAIL stream_c4_instr got=%h want=%h", instr_a, word(32'h0)); end
        checks++; if (req_valid_a !== 1'b0) begin fails++; $display("FAIL stream_c4_credit got=%b want=0", req_valid_a); end
        tick();
        checks++; if (pcp8_a !== 32'hC || req_addr_a !== 32'h8 || req_valid_a !== 1'b1) begin fails++; $display("FAIL stream_c5 pcp8=%h addr=%h v=%b want 0000000c/00000008/1", pcp8_a, req_addr_a, req_valid_a); end
        tick();
        checks++; if (iv_a !== 1'b0 || req_addr_a !== 32'hC) begin fails++; $display("FAIL stream_c6 iv=%b addr=%h want 0/0000000c", iv_a, req_addr_a); end
        tick();
        checks++; if (iv_a !== 1'b1 || pcp8_a !== 32'h10) begin fails++; $display("FAIL stream_c7 iv=%b pcp8=%h want 1/00000010", iv_a, pcp8_a); end
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        do_reset();
        repeat (8) tick();
        checks++; if (acc_cnt_a != 2) begin fails++; $display("FAIL bp_accepts got=%0d want=2", acc_cnt_a); end
        checks++; if (req_valid_a !== 1'b0) begin fails++; $display("FAIL bp_req_stalled got=%b want=0", req_valid_a); end
        checks++; if (iv_a !== 1'b1 || pcp8_a !== 32'h8 || instr_a !== word(32'h0)) begin fails++; $display("FAIL bp_head0 iv=%b pcp8=%h instr=%h", iv_a, pcp8_a, instr_a); end
        instr_ready = 1'b1;
        tick();
        checks++; if (pcp8_a !== 32'hC || instr_a !== word(32'h4)) begin fails++; $display("FAIL bp_head4 pcp8=%h instr=%h want 0000000c/%h", pcp8_a, instr_a, word(32'h4)); end
        checks++; if (req_valid_a !== 1'b1 || req_addr_a !== 32'h8) begin fails++; $display("FAIL bp_resume v=%b addr=%h want 1/00000008", req_valid_a, req_addr_a); end
        tick();
        checks++; if (iv_a !== 1'b0) begin fails++; $display("FAIL bp_drained iv=%b want=0", iv_a); end
    endtask

    task automatic test_redirect();
        instr_ready = 1'b1; imem_req_ready = 1'b1;
        do_reset();
        repeat (4) tick();
        checks++; if (pcp8_a !== 32'hC || req_addr_a !== 32'h8) begin fails++; $display("FAIL redir_setup pcp8=%h addr=%h want 0000000c/00000008", pcp8_a, req_addr_a); end
        PCSrc = 1'b1; Result = 32'h0000_0103;
        tick();
        PCSrc = 1'b0;
        checks++; if (req_valid_a !== 1'b0 || iv_a !== 1'b0) begin fails++; $display("FAIL redir_drain v=%b iv=%b want 0/0", req_valid_a, iv_a); end
        tick();
        checks++; if (req_valid_a !== 1'b1 || req_addr_a !== 32'h100 || iv_a !== 1'b0) begin fails++; $display("FAIL redir_target v=%b addr=%h iv=%b want 1/00000100/0", req_valid_a, req_addr_a, iv_a); end
        repeat (2) tick();
        checks++; if (iv_a !== 1'b1 || pcp8_a !== 32'h108 || instr_a !== word(32'h100)) begin fails++; $display("FAIL redir_deliver iv=%b pcp8=%h instr=%h want 1/00000108/%h", iv_a, pcp8_a, instr_a, word(32'h100)); end
    endtask

    task automatic test_withdraw();
        instr_ready = 1'b1; imem_req_ready = 1'b1;
        do_reset();
        repeat (4) tick();
        imem_req_ready = 1'b0; instr_ready = 1'b0;
        tick();
        checks++; if (req_valid_a !== 1'b1 || req_addr_a !== 32'h8) begin fails++; $display("FAIL wd_pending v=%b addr=%h want 1/00000008", req_valid_a, req_addr_a); end
        repeat (2) tick();
        checks++; if (req_valid_a !== 1'b1 || req_addr_a !== 32'h8 || pcp8_a !== 32'hC) begin fails++; $display("FAIL wd_stable v=%b addr=%h pcp8=%h", req_valid_a, req_addr_a, pcp8_a); end
        instr_ready = 1'b1; PCSrc = 1'b1; Result = 32'h0000_0040;
        tick();
        PCSrc = 1'b0; imem_req_ready = 1'b1;
        checks++; if (req_valid_a !== 1'b1 || req_addr_a !== 32'h40 || iv_a !== 1'b0) begin fails++; $display("FAIL wd_target v=%b addr=%h iv=%b want 1/00000040/0", req_valid_a, req_addr_a, iv_a); end
        tick();
        checks++; if (last_acc_a !== 32'h40 || acc_cnt_a != 3) begin fails++; $display("FAIL wd_accepts last=%h cnt=%0d want 00000040/3", last_acc_a, acc_cnt_a); end
        checks++; if (iv_a !== 1'b0) begin fails++; $display("FAIL wd_no_wrong_path iv=%b want=0", iv_a); end
        tick();
        checks++; if (iv_a !== 1'b1 || pcp8_a !== 32'h48) begin fails++; $display("FAIL wd_deliver iv=%b pcp8=%h want 1/00000048", iv_a, pcp8_a); end
    endtask

    task automatic test_wrap();
        instr_ready = 1'b1; imem_req_ready = 1'b1;
        do_reset();
        tick();
        checks++; if (req_valid_b !== 1'b1 || req_addr_b !== 32'hFFFF_FFF8) begin fails++; $display("FAIL wrap_addr0 v=%b addr=%h want 1/fffffff8", req_valid_b, req_addr_b); end
        tick();
        checks++; if (req_addr_b !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr1 got=%h want=fffffffc", req_addr_b); end
        tick();
        checks++; if (req_addr_b !== 32'h0 || iv_b !== 1'b1 || pcp8_b !== 32'h0) begin fails++; $display("FAIL wrap_addr2 addr=%h iv=%b pcp8=%h want 00000000/1/00000000", req_addr_b, iv_b, pcp8_b); end
        tick();
        checks++; if (pcp8_b !== 32'h4 || instr_b !== word(32'hFFFF_FFFC)) begin fails++; $display("FAIL wrap_pcp8 pcp8=%h instr=%h want 00000004/%h", pcp8_b, instr_b, word(32'hFFFF_FFFC)); end
        #2 reset = 1'b0;
        #1;
        checks++; if (req_valid_b !== 1'b0 || iv_b !== 1'b0 || instr_b !== 32'h0 || pcp8_b !== 32'h0) begin fails++; $display("FAIL midrst_outputs v=%b iv=%b instr=%h pcp8=%h want all 0", req_valid_b, iv_b, instr_b, pcp8_b); end
        checks++; if (iv_a !== 1'b0 || req_valid_a !== 1'b0) begin fails++; $display("FAIL midrst_a iv=%b v=%b want 0/0", iv_a, req_valid_a); end
        do_reset();
        tick();
        checks++; if (req_valid_b !== 1'b1 || req_addr_b !== 32'hFFFF_FFF8) begin fails++; $display("FAIL midrst_refetch v=%b addr=%h want 1/fffffff8", req_valid_b, req_addr_b); end
    endtask

    task automatic test_coincide();
        instr_ready = 1'b1; imem_req_ready = 1'b1;
        do_reset();
        repeat (3) tick();
        checks++; if (iv_b !== 1'b1 || req_valid_b !== 1'b1 || req_addr_b !== 32'h0 || rsp_valid_b !== 1'b1) begin fails++; $display("FAIL coin_setup iv=%b v=%b addr=%h rsp=%b", iv_b, req_valid_b, req_addr_b, rsp_valid_b); end
        PCSrc = 1'b1; Result = 32'h0000_0200;
        tick();
        PCSrc = 1'b0;
        checks++; if (req_valid_b !== 1'b0 || iv_b !== 1'b0) begin fails++; $display("FAIL coin_drain v=%b iv=%b want 0/0", req_valid_b, iv_b); end
        tick();
        checks++; if (req_valid_b !== 1'b1 || req_addr_b !== 32'h200 || iv_b !== 1'b0) begin fails++; $display("FAIL coin_resume v=%b addr=%h iv=%b want 1/00000200/0", req_valid_b, req_addr_b, iv_b); end
        repeat (2) tick();
        checks++; if (iv_b !== 1'b1 || pcp8_b !== 32'h208 || instr_b !== word(32'h200)) begin fails++; $display("FAIL coin_deliver iv=%b pcp8=%h instr=%h want 1/00000208/%h", iv_b, pcp8_b, instr_b, word(32'h200)); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_withdraw();
        test_wrap();
        test_coincide();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
